// File: rtl/prog_loader.sv
// Program loader for byteblast8: takes a length-prefixed byte stream and writes it into RAM from address 0.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_BITS    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_in_valid,
    input  logic [DATA_BITS-1:0]    i_in_data,
    output logic                    o_in_ready,
    output logic                    o_ram_w_enable,
    output logic [ADDRESS_BITS-1:0] o_ram_address,
    output logic [DATA_BITS-1:0]    o_ram_data,
    output logic                    o_cpu_enable,
    output logic                    o_busy,
    output logic                    o_error
);

    localparam int          CNT_W    = ADDRESS_BITS + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDRESS_BITS;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR} state_t;
`endif

    state_t                  r_state;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_len;
    logic                    r_commit;
    logic                    r_in_ready;
    logic                    r_ram_w_enable;
    logic [ADDRESS_BITS-1:0] r_ram_address;
    logic [DATA_BITS-1:0]    r_ram_data;
    logic                    r_cpu_enable;
    logic                    r_busy;
    logic                    r_error;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_BITS-1:0]    r_sum;
`endif

    logic w_accept;
    logic w_len_too_big;
    logic w_len_zero;
    logic w_last;

    assign w_accept      = i_in_valid && r_in_ready;
    assign w_len_too_big = (32'(i_in_data) > CAPACITY);
    assign w_len_zero    = (i_in_data == '0);
    assign w_last        = ((r_count + CNT_W'(1)) == r_len);

    assign o_in_ready     = r_in_ready;
    assign o_ram_w_enable = r_ram_w_enable;
    assign o_ram_address  = r_ram_address;
    assign o_ram_data     = r_ram_data;
    assign o_cpu_enable   = r_cpu_enable;
    assign o_busy         = r_busy;
    assign o_error        = r_error;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_len          <= '0;
            r_commit       <= 1'b0;
            r_in_ready     <= 1'b0;
            r_ram_w_enable <= 1'b0;
            r_ram_address  <= '0;
            r_ram_data     <= '0;
            r_cpu_enable   <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum          <= '0;
`endif
        end else begin
            r_ram_w_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_LEN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_error      <= 1'b0;
                        r_cpu_enable <= 1'b0;
                        r_commit     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum        <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (w_accept) begin
                        if (w_len_too_big) begin
                            r_state    <= ST_ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_len_zero) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
`else
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_commit   <= 1'b1;
`endif
                        end else begin
                            r_len   <= CNT_W'(i_in_data);
                            r_count <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_ram_w_enable <= 1'b1;
                        r_ram_address  <= r_count[ADDRESS_BITS-1:0];
                        r_ram_data     <= i_in_data;
                        r_count        <= r_count + CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum          <= r_sum + i_in_data;
`endif
                        // busy stays high through the final write; DONE releases it once RAM has it
                        if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
`else
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_commit   <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (i_in_data == r_sum) begin
                            r_state  <= ST_DONE;
                            r_commit <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (i_start) begin
                        r_state      <= ST_LEN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_error      <= 1'b0;
                        r_cpu_enable <= 1'b0;
                        r_commit     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum        <= '0;
`endif
                    end else if (r_commit) begin
                        r_commit     <= 1'b0;
                        r_cpu_enable <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (i_start) begin
                        r_state      <= ST_LEN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_error      <= 1'b0;
                        r_cpu_enable <= 1'b0;
                        r_commit     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum        <= '0;
`endif
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
